// File: rtl/ascon_aead_arbiter.sv
// ascon_aead_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of one shared
// Ascon AEAD encryption core. On a grant, the winner's key, nonce, associated
// data and plaintext are latched and driven to the core. The arbiter then
// pulses core_start and waits for the core to complete. It captures the
// ciphertext and tag and pulses the owner's done flag for one cycle.
//
// Optional feature: define ASCON_ARB_TIMEOUT_EN to build a WAIT-state
// watchdog. When it expires, the operation finishes with err=1 and zeroed
// results. Without the macro, WAIT waits indefinitely and err is tied to 0.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid                  request from requester N (held until done)
//   reqN_key/nonce/ad/pt        requester N operands, sampled on grant
//   reqN_done                   one-cycle completion pulse to requester N
//   core_key/nonce/ad/pt        latched operands to the core
//   core_start                  one-cycle start pulse to the core
//   core_ready                  core completion level
//   core_cipher, core_tag       core results
//   res_cipher, res_tag         results of the last completed operation
//   res_owner                   requester index of the last result
//   busy                        high whenever the sequencer is not idle
//   err                         one-cycle watchdog expiry pulse
module ascon_aead_arbiter #(
   parameter int K              = 128,
   parameter int L              = 40,
   parameter int Y              = 40,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   input  logic [K-1:0]   req0_key,
   input  logic [127:0]   req0_nonce,
   input  logic [L-1:0]   req0_ad,
   input  logic [Y-1:0]   req0_pt,
   output logic           req0_done,
   input  logic           req1_valid,
   input  logic [K-1:0]   req1_key,
   input  logic [127:0]   req1_nonce,
   input  logic [L-1:0]   req1_ad,
   input  logic [Y-1:0]   req1_pt,
   output logic           req1_done,
   output logic [K-1:0]   core_key,
   output logic [127:0]   core_nonce,
   output logic [L-1:0]   core_ad,
   output logic [Y-1:0]   core_pt,
   output logic           core_start,
   input  logic           core_ready,
   input  logic [Y-1:0]   core_cipher,
   input  logic [127:0]   core_tag,
   output logic [Y-1:0]   res_cipher,
   output logic [127:0]   res_tag,
   output logic           res_owner,
   output logic           busy,
   output logic           err
);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

   state_t state;
   logic   owner;
   logic   last_grant;
   logic   seen_busy;
   logic   grant_any;
   logic   grant_sel;
   logic   complete;

   // Round-robin pick: on a tie, the requester that was not served last wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_sel = 1'b0;
      if (req0_valid && req1_valid)
         grant_sel = ~last_grant;
      else if (req1_valid)
         grant_sel = 1'b1;
   end

   // Completion needs ready to have dropped during this operation first.
   // A ready level left over from the previous operation is ignored.
   assign complete = seen_busy & core_ready;

`ifdef ASCON_ARB_TIMEOUT_EN
   logic [15:0] wd_cnt;
   logic        expired;
   assign expired = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   // The watchdog limit has no effect in this build.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         seen_busy  <= 1'b0;
         core_key   <= '0;
         core_nonce <= '0;
         core_ad    <= '0;
         core_pt    <= '0;
         core_start <= 1'b0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         res_cipher <= '0;
         res_tag    <= '0;
         res_owner  <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
         err        <= 1'b0;
         wd_cnt     <= '0;
`endif
      end else begin
         // Pulse outputs default low; each is raised for exactly one state.
         core_start <= 1'b0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
         err        <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  owner      <= grant_sel;
                  last_grant <= grant_sel;
                  core_key   <= grant_sel ? req1_key   : req0_key;
                  core_nonce <= grant_sel ? req1_nonce : req0_nonce;
                  core_ad    <= grant_sel ? req1_ad    : req0_ad;
                  core_pt    <= grant_sel ? req1_pt    : req0_pt;
                  core_start <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               seen_busy <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
               wd_cnt    <= '0;
`endif
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!core_ready)
                  seen_busy <= 1'b1;
               if (complete) begin
                  res_cipher <= core_cipher;
                  res_tag    <= core_tag;
                  res_owner  <= owner;
                  req0_done  <= ~owner;
                  req1_done  <= owner;
                  state      <= ST_DONE;
               end
`ifdef ASCON_ARB_TIMEOUT_EN
               // Completion takes priority over expiry in the same cycle.
               else if (expired) begin
                  res_cipher <= '0;
                  res_tag    <= '0;
                  res_owner  <= owner;
                  req0_done  <= ~owner;
                  req1_done  <= owner;
                  err        <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
`endif
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ascon_aead_arbiter.sv
// Testbench for ascon_aead_arbiter. A behavioural core model answers
// core_start with a programmable ready profile. Expected results come from
// the operands the bench chose and a round-robin reference model.
module tb_ascon_aead_arbiter;
   localparam int K = 128;
   localparam int L = 40;
   localparam int Y = 40;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req1_valid;
   logic [K-1:0]   req0_key, req1_key;
   logic [127:0]   req0_nonce, req1_nonce;
   logic [L-1:0]   req0_ad, req1_ad;
   logic [Y-1:0]   req0_pt, req1_pt;
   logic           req0_done, req1_done;
   logic [K-1:0]   core_key;
   logic [127:0]   core_nonce;
   logic [L-1:0]   core_ad;
   logic [Y-1:0]   core_pt;
   logic           core_start;
   logic           core_ready;
   logic [Y-1:0]   core_cipher;
   logic [127:0]   core_tag;
   logic [Y-1:0]   res_cipher;
   logic [127:0]   res_tag;
   logic           res_owner;
   logic           busy;
   logic           err;

   ascon_aead_arbiter #(.K(K), .L(L), .Y(Y), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_key(req0_key), .req0_nonce(req0_nonce),
      .req0_ad(req0_ad), .req0_pt(req0_pt), .req0_done(req0_done),
      .req1_valid(req1_valid), .req1_key(req1_key), .req1_nonce(req1_nonce),
      .req1_ad(req1_ad), .req1_pt(req1_pt), .req1_done(req1_done),
      .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad),
      .core_pt(core_pt), .core_start(core_start), .core_ready(core_ready),
      .core_cipher(core_cipher), .core_tag(core_tag),
      .res_cipher(res_cipher), .res_tag(res_tag), .res_owner(res_owner),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // Operands currently presented by each requester.
   logic [K-1:0]   op_key   [2];
   logic [127:0]   op_nonce [2];
   logic [L-1:0]   op_ad    [2];
   logic [Y-1:0]   op_pt    [2];
   int             m_last;

   // Stand-in for the encryption transform: any fixed mixing of all operands.
   function automatic logic [Y-1:0] ref_cipher(input logic [K-1:0] k, input logic [127:0] n,
                                               input logic [L-1:0] a, input logic [Y-1:0] p);
      return p ^ k[Y-1:0] ^ a ^ n[Y-1:0];
   endfunction

   function automatic logic [127:0] ref_tag(input logic [K-1:0] k, input logic [127:0] n,
                                            input logic [L-1:0] a, input logic [Y-1:0] p);
      return k ^ {n[63:0], n[127:64]} ^ {48'h0, a, p};
   endfunction

   // Round-robin reference: a tie goes to whoever was not served last.
   function automatic int pick(input bit v0, input bit v1);
      if (v0 && v1) return 1 - m_last;
      return v1 ? 1 : 0;
   endfunction

   // Behavioural core. Ready is high for m_hold cycles from the start cycle,
   // then low for m_lat cycles, then high with results (never, if m_never).
   int             m_hold = 0;
   int             m_lat = 20;
   bit             m_never = 1'b0;
   bit             m_act = 1'b0;
   int             m_c = 0;
   int             rise_cyc = -1;
   logic [Y-1:0]   m_cipher;
   logic [127:0]   m_tag;

   always begin
      @(posedge clk);
      #2;
      if (core_start) begin
         m_act    = 1'b1;
         m_c      = 0;
         m_cipher = ref_cipher(core_key, core_nonce, core_ad, core_pt);
         m_tag    = ref_tag(core_key, core_nonce, core_ad, core_pt);
      end else if (m_act) begin
         m_c++;
      end
      if (m_act) begin
         if (m_c < m_hold) begin
            if (!core_ready) rise_cyc = cyc;
            core_ready = 1'b1;
         end else if (m_never || m_c < m_hold + m_lat) begin
            core_ready = 1'b0;
         end else begin
            core_cipher = m_cipher;
            core_tag    = m_tag;
            if (!core_ready) rise_cyc = cyc;
            core_ready  = 1'b1;
            m_act       = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops();
      req0_key = op_key[0]; req0_nonce = op_nonce[0]; req0_ad = op_ad[0]; req0_pt = op_pt[0];
      req1_key = op_key[1]; req1_nonce = op_nonce[1]; req1_ad = op_ad[1]; req1_pt = op_pt[1];
   endtask

   task automatic rand_ops(input int r);
      op_key[r]   = {$urandom, $urandom, $urandom, $urandom};
      op_nonce[r] = {$urandom, $urandom, $urandom, $urandom};
      op_ad[r]    = {$urandom, 8'($urandom)};
      op_pt[r]    = {$urandom, 8'($urandom)};
      drive_ops();
   endtask

   // Follows one operation expected to be owned by requester o. exp_n is the
   // number of samples until core_start. With drop set, both valids are
   // released at done; otherwise the owner re-requests with fresh operands.
   task automatic run_op(input int o, input int exp_n, input bit drop, input string name);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      while (n < 10 && !got) begin
         tick();
         n++;
         got = core_start;
      end
      chk({name, "_start_lat"}, n, exp_n);
      if (!got) return;
      chk({name, "_core_pt"}, core_pt, op_pt[o]);
      chk({name, "_core_key"}, core_key, op_key[o]);
      chk({name, "_busy"}, busy, 1'b1);
      rise_cyc = -1;
      n = 0;
      got = 1'b0;
      while (n < 300 && !got) begin
         tick();
         n++;
         got = req0_done | req1_done;
      end
      chk({name, "_done_lat"}, cyc, rise_cyc + 1);
      chk({name, "_done0"}, req0_done, (o == 0));
      chk({name, "_done1"}, req1_done, (o == 1));
      chk({name, "_res_cipher"}, res_cipher, ref_cipher(op_key[o], op_nonce[o], op_ad[o], op_pt[o]));
      chk({name, "_res_tag"}, res_tag, ref_tag(op_key[o], op_nonce[o], op_ad[o], op_pt[o]));
      chk({name, "_res_owner"}, res_owner, o[0]);
      m_last = o;
      if (drop) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end else begin
         rand_ops(o);
      end
   endtask

   initial begin
      int  o;
      int  n;
      int  errs;
      bit  v0, v1;
      bit  got;
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      core_ready = 1'b0;
      core_cipher = '0;
      core_tag = '0;
      m_last = 1;
      rand_ops(0);
      rand_ops(1);
      tick();
      tick();

      // Reset state
      chk("rst_busy", busy, 1'b0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_done0", req0_done, 1'b0);
      chk("rst_done1", req1_done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_res_cipher", res_cipher, '0);
      chk("rst_res_tag", res_tag, '0);
      chk("rst_res_owner", res_owner, 1'b0);
      chk("rst_core_key", core_key, '0);
      chk("rst_core_pt", core_pt, '0);
      rst = 1'b0;
      tick();

      // Single directed request from requester 0
      op_key[0]   = 128'h000102030405060708090A0B0C0D0E0F;
      op_nonce[0] = 128'h101112131415161718191A1B1C1D1E1F;
      op_ad[0]    = 40'h4153434F4E;
      op_pt[0]    = 40'h6173636F6E;
      drive_ops();
      m_hold = 0;
      m_lat = 20;
      req0_valid = 1'b1;
      run_op(0, 1, 1'b1, "t1");
      tick();
      chk("t1_idle_busy", busy, 1'b0);
      chk("t1_idle_done0", req0_done, 1'b0);

      // Continuous dual requests after reset: grants alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last = 1;
      rand_ops(0);
      rand_ops(1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_lat = $urandom_range(2, 12);
         o = pick(1'b1, 1'b1);
         chk($sformatf("dual%0d_order", i), o, i % 2);
         run_op(o, (i == 0) ? 1 : 2, (i == 3), $sformatf("dual%0d", i));
      end
      tick();
      chk("dual_idle_busy", busy, 1'b0);

      // Stale ready: core_ready still high from the last op and held high
      // for three cycles after start before the core goes busy.
      m_hold = 4;
      m_lat = 6;
      rand_ops(0);
      req0_valid = 1'b1;
      run_op(0, 1, 1'b1, "stale");
      tick();
      m_hold = 0;

      // Reset while in WAIT drops the operation without a done pulse
      m_lat = 30;
      rand_ops(1);
      req1_valid = 1'b1;
      tick();
      chk("rw_start", core_start, 1'b1);
      tick();
      tick();
      tick();
      chk("rw_busy_wait", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_busy", busy, 1'b0);
      chk("rw_core_start", core_start, 1'b0);
      chk("rw_done0", req0_done, 1'b0);
      chk("rw_done1", req1_done, 1'b0);
      chk("rw_err", err, 1'b0);
      chk("rw_res_tag", res_tag, '0);
      chk("rw_res_cipher", res_cipher, '0);
      chk("rw_core_pt", core_pt, '0);
      m_last = 1;
      run_op(1, 1, 1'b1, "after_rst");
      tick();

      // Randomized request patterns and core latencies
      for (int i = 0; i < 12; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         m_lat = $urandom_range(2, 10);
         m_hold = $urandom_range(0, 2);
         rand_ops(0);
         rand_ops(1);
         req0_valid = v0;
         req1_valid = v1;
         o = pick(v0, v1);
         run_op(o, 1, 1'b1, $sformatf("rnd%0d", i));
         tick();
         chk($sformatf("rnd%0d_idle", i), busy, 1'b0);
      end
      m_hold = 0;

      // Core never raises ready
      m_never = 1'b1;
      rand_ops(0);
      req0_valid = 1'b1;
      tick();
      chk("to_start", core_start, 1'b1);
`ifdef ASCON_ARB_TIMEOUT_EN
      n = 0;
      got = 1'b0;
      while (n < 30 && !got) begin
         tick();
         n++;
         got = err | req0_done;
      end
      chk("to_lat", n, 9);
      chk("to_err", err, 1'b1);
      chk("to_done0", req0_done, 1'b1);
      chk("to_res_tag", res_tag, '0);
      chk("to_res_cipher", res_cipher, '0);
      chk("to_res_owner", res_owner, 1'b0);
      req0_valid = 1'b0;
      tick();
      chk("to_err_pulse", err, 1'b0);
      chk("to_idle", busy, 1'b0);
`else
      errs = 0;
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (err) errs++;
         if (req0_done) got = 1'b1;
      end
      chk("noto_busy", busy, 1'b1);
      chk("noto_err_count", errs, 0);
      chk("noto_done", got, 1'b0);
      chk("noto_err", err, 1'b0);
      n = errs;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ascon_aead_arbiter.md
Name: ascon_aead_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared Ascon AEAD encryption core. The core is parameterised by k, l and y, and has a start pulse and a ready level.
- Latches the granted requester's key, nonce, associated data and plaintext, and drives them to the core.
- Pulses the core start, waits for completion, and returns ciphertext and tag with a per-requester done pulse.
- Sits between SoC-side input loaders and the encryption core.

Parameters:
- K, 128, key width in bits
- L, 40, associated data width in bits
- Y, 40, plaintext/ciphertext width in bits
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles; used only with ASCON_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 operation request
- req0_key  in  K  requester 0 key
- req0_nonce  in  128  requester 0 nonce
- req0_ad  in  L  requester 0 associated data
- req0_pt  in  Y  requester 0 plaintext
- req0_done  out  1  one-cycle completion pulse, requester 0
- req1_valid, req1_key, req1_nonce, req1_ad, req1_pt, req1_done  same as requester 0
- core_key  out  K  operand to core
- core_nonce  out  128  operand to core
- core_ad  out  L  operand to core
- core_pt  out  Y  operand to core
- core_start  out  1  one-cycle start pulse to core
- core_ready  in  1  core completion level
- core_cipher  in  Y  core ciphertext
- core_tag  in  128  core tag
- res_cipher  out  Y  registered ciphertext of last completed operation
- res_tag  out  128  registered tag of last completed operation
- res_owner  out  1  requester index of last result
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle timeout pulse; tied 0 without macro

Behaviour:
- Synchronous, active-high reset. It clears all outputs and operand/result registers to 0, sets state=IDLE, and sets last_grant=1 so requester 0 wins the first tie.
- Reset mid-operation returns to IDLE immediately; core_start stays 0, and the operation in flight is dropped with no done pulse.
- States are IDLE, START, WAIT, DONE.
- IDLE:
  - Sample reqN_valid. Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On grant, in the same edge: latch that requester's operands into core_* registers, set owner and last_grant, and go to START.
  - No valid: stay in IDLE.
- START:
  - core_start=1 for exactly this cycle; clear seen_busy; go to WAIT.
  - Operands are stable from START until the next grant.
- WAIT:
  - If core_ready==0, set seen_busy.
  - Completion is seen_busy && core_ready==1. This means a stale ready level from a previous operation is never taken as completion.
  - On completion: capture core_cipher to res_cipher, core_tag to res_tag, owner to res_owner, and go to DONE.
- DONE:
  - req{owner}_done=1 for this one cycle, then go to IDLE.
  - res_* remain valid and held until the next completion overwrites them.
- Latency: grant edge to core_start is 1 cycle. Core completion to done pulse is 1 cycle.
- Minimum gap between back-to-back operations is 3 cycles plus core time.
- Requester protocol:
  - Hold reqN_valid high until reqN_done is seen.
  - Deassert valid in the cycle after done.
  - valid still high in IDLE is treated as a new request.
  - Operand inputs need only be stable in the cycle of grant.
- Valid changes while not in IDLE are ignored until the next return to IDLE.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1,...
- busy = (state != IDLE).

Optional Feature:
- Macro: ASCON_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears in START and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without completion, go to DONE with err=1 during the DONE cycle.
  - The owner's done pulses with it; res_cipher and res_tag are written to 0 and res_owner to owner.
  - Completion and expiry in the same cycle: completion wins and err stays 0.
- Disabled: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Test Plan:
- Reset then req0_valid only, key=0x000102...0F, nonce=0x101112...1F, ad=0x4153434F4E, pt=0x6173636F6E. The core model drops ready on start and raises it after 20 cycles.
  - Required: core_start pulses 1 cycle after grant; req0_done pulses 1 cycle after ready rises.
  - Required: res_cipher and res_tag match the model; res_owner=0.
- req0 and req1 asserted together and held, re-requesting after each done.
  - Required: grant order 0,1,0,1; core_pt alternates between the two plaintexts; each done goes only to its own requester.
- core_ready left high from a prior operation and held high for 3 cycles after core_start before dropping.
  - Required: no completion until ready goes low then high again.
- rst asserted for 1 cycle in WAIT.
  - Required: next cycle state=IDLE, busy=0, all outputs 0, no done pulse; a following req1 request completes normally.
- With ASCON_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the core never raises ready.
  - Required: err and req0_done pulse together 9 cycles after core_start; res_tag=0.
  - Without the macro: busy stays 1 and err stays 0.
